// File: rtl/cw_keyer_if.sv
// Command bus between the command decoder and the CW keyer.
// The decoder drives the bus through the master modport.
// The keyer samples it through the slave modport.
interface cw_keyer_if;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_rqst;

  modport master (output cmd_addr, output cmd_data, output cmd_rqst);
  modport slave  (input cmd_addr, input cmd_data, input cmd_rqst);
endinterface

// File: rtl/cw_keyer.sv
// CW keying controller.
// Keys the transmitter from a straight key or from an iambic paddle pair,
// using an internal iambic mode A/B element generator. The RF key is delayed
// by DELAY_MS so the T/R switch can settle first. TX power is held for a
// hang time after the last element. All timing advances on msec_pulse.
module cw_keyer #(
  parameter int DELAY_MS   = 8,
  parameter int HANG_W     = 10,
  parameter int DECAY_MS   = 4,
  parameter int DOT_MS_RST = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  cw_keyer_if.slave        cmd,
  input  logic             msec_pulse,
  input  logic             dot_key_debounced,
  input  logic             dash_key_debounced,
  output logic             cw_power_on,
  output logic             cw_keydown,
  output logic [1:0]       cw_element
);

  // The state encoding doubles as the cw_element output code.
  typedef enum logic [1:0] {KIDLE = 2'b00, DOT = 2'b01, DASH = 2'b10, GAP = 2'b11} gen_state_t;
  typedef enum logic [1:0] {IDLE, PREKEY, KEY, POSTKEY} pwr_state_t;

  logic [HANG_W-1:0]   hang_time;
  logic [7:0]          dot_ms;
  logic [1:0]          mode;
  logic                reverse;

  gen_state_t          gen_state, gen_next;
  logic [9:0]          elem_cnt, cnt_next;
  logic                memory, mem_next;
  logic                last_dash, last_next;
  logic                opp, same, start_el, start_dash;

  pwr_state_t          pwr_state, pwr_next;
  logic [DELAY_MS-1:0] delay_line;
  logic [HANG_W-1:0]   hang_cnt, hang_load, hang_dec;

  logic                dot_in, dash_in, iambic, mode_b, keyed;
  logic [9:0]          dot_len, dash_len, hang_cmd;
  logic                unused_cmd_bits;

  assign hang_cmd        = {cmd.cmd_data[31:24], cmd.cmd_data[17:16]};
  assign unused_cmd_bits = ^{cmd.cmd_data[23:18], cmd.cmd_data[15:11]};

  assign dot_in   = reverse ? dash_key_debounced : dot_key_debounced;
  assign dash_in  = reverse ? dot_key_debounced : dash_key_debounced;
  assign iambic   = (mode == 2'b01) || (mode == 2'b10);
  assign mode_b   = (mode == 2'b10);
  assign keyed    = iambic ? ((gen_state == DOT) || (gen_state == DASH)) : dot_in;

  // Dash is three dots; 255*3 still fits in 10 bits.
  assign dot_len  = {2'b00, dot_ms};
  assign dash_len = dot_len + {dot_len[8:0], 1'b0};

  assign hang_load = hang_time + HANG_W'(DECAY_MS);
  assign hang_dec  = hang_cnt - 1'b1;

  assign cw_element = gen_state;

  // Configuration registers written from the command bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_time <= '0;
      dot_ms    <= 8'(DOT_MS_RST);
      mode      <= 2'b00;
      reverse   <= 1'b0;
    end else if (cmd.cmd_rqst) begin
      if (cmd.cmd_addr == 6'h10) begin
        hang_time <= HANG_W'(hang_cmd);
      end else if (cmd.cmd_addr == 6'h0B) begin
        dot_ms  <= (cmd.cmd_data[7:0] == 8'd0) ? 8'd1 : cmd.cmd_data[7:0];
        mode    <= cmd.cmd_data[9:8];
        reverse <= cmd.cmd_data[10];
      end
    end
  end

  // Element generator next state: element timing, gap decision and mode B memory.
  always_comb begin
    gen_next   = gen_state;
    cnt_next   = elem_cnt;
    mem_next   = memory;
    last_next  = last_dash;
    opp        = 1'b0;
    same       = 1'b0;
    start_el   = 1'b0;
    start_dash = 1'b0;
    if (msec_pulse) begin
      if (!iambic) begin
        gen_next = KIDLE;
        mem_next = 1'b0;
      end else begin
        case (gen_state)
          KIDLE: begin
            start_el   = dot_in || dash_in;
            start_dash = !dot_in;
          end
          DOT, DASH: begin
            opp = (gen_state == DOT) ? dash_in : dot_in;
            if (mode_b && opp) mem_next = 1'b1;
            if (elem_cnt <= 10'd1) begin
              gen_next  = GAP;
              cnt_next  = dot_len;
              last_next = (gen_state == DASH);
            end else begin
              cnt_next = elem_cnt - 10'd1;
            end
          end
          GAP: begin
            opp  = last_dash ? dot_in : dash_in;
            same = last_dash ? dash_in : dot_in;
            if (mode_b && opp) mem_next = 1'b1;
            if (elem_cnt <= 10'd1) begin
              if (opp || (mode_b && memory)) begin
                start_el   = 1'b1;
                start_dash = !last_dash;
              end else if (same) begin
                start_el   = 1'b1;
                start_dash = last_dash;
              end else begin
                gen_next = KIDLE;
              end
            end else begin
              cnt_next = elem_cnt - 10'd1;
            end
          end
          default: gen_next = KIDLE;
        endcase
        if (start_el) begin
          gen_next = start_dash ? DASH : DOT;
          cnt_next = start_dash ? dash_len : dot_len;
          mem_next = 1'b0;
        end
      end
    end
  end

  // Element generator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_state <= KIDLE;
      elem_cnt  <= '0;
      memory    <= 1'b0;
      last_dash <= 1'b0;
    end else begin
      gen_state <= gen_next;
      elem_cnt  <= cnt_next;
      memory    <= mem_next;
      last_dash <= last_next;
    end
  end

  // Power FSM next state; an expiring hang counter beats a new key press.
  always_comb begin
    pwr_next = pwr_state;
    if (msec_pulse) begin
      case (pwr_state)
        IDLE:    if (keyed) pwr_next = PREKEY;
        PREKEY:  if (delay_line[DELAY_MS-1]) pwr_next = KEY;
                 else if (delay_line == '0) pwr_next = IDLE;
        KEY:     if (!delay_line[DELAY_MS-1]) pwr_next = POSTKEY;
        POSTKEY: if (hang_dec == '0) pwr_next = IDLE;
                 else if (keyed) pwr_next = PREKEY;
        default: pwr_next = IDLE;
      endcase
    end
  end

  // Power FSM state, delay line, hang counter and registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_state   <= IDLE;
      delay_line  <= '0;
      hang_cnt    <= '0;
      cw_power_on <= 1'b0;
      cw_keydown  <= 1'b0;
    end else begin
      pwr_state   <= pwr_next;
      cw_power_on <= (pwr_next != IDLE);
      cw_keydown  <= (pwr_next == KEY);
      if (msec_pulse) begin
        delay_line <= {delay_line[DELAY_MS-2:0], keyed};
        hang_cnt   <= (pwr_state == POSTKEY) ? hang_dec : hang_load;
      end
    end
  end

endmodule

// File: tb/tb_cw_keyer.sv
// Self-checking bench for cw_keyer with default parameters
// (DELAY_MS=8, HANG_W=10, DECAY_MS=4, DOT_MS_RST=60).
// Pulse numbering: pulse 1 is the first msec_pulse that sees the new key state.
module tb_cw_keyer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msec_pulse;
  logic       dot_key;
  logic       dash_key;
  logic       cw_power_on;
  logic       cw_keydown;
  logic [1:0] cw_element;

  int tests_run = 0;
  int tests_failed = 0;

  cw_keyer_if cif ();

  cw_keyer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd                (cif.slave),
    .msec_pulse         (msec_pulse),
    .dot_key_debounced  (dot_key),
    .dash_key_debounced (dash_key),
    .cw_power_on        (cw_power_on),
    .cw_keydown         (cw_keydown),
    .cw_element         (cw_element)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dot;
    logic       dash;
    int         pulses;
    logic       exp_power;
    logic       exp_keydown;
    logic [1:0] exp_elem;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_pulse();
    @(negedge clk);
    msec_pulse = 1'b1;
    @(negedge clk);
    msec_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic dot, input logic dash, input int n);
    dot_key  = dot;
    dash_key = dash;
    for (int i = 0; i < n; i++) do_pulse();
  endtask

  task automatic write_cmd(input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk);
    cif.cmd_addr = addr;
    cif.cmd_data = data;
    cif.cmd_rqst = 1'b1;
    @(negedge clk);
    cif.cmd_rqst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, " power"}, 32'(cw_power_on), 32'd0);
    checkOutput({tag, " keydown"}, 32'(cw_keydown), 32'd0);
    checkOutput({tag, " element"}, 32'(cw_element), 32'd0);
  endtask

  // Runs the squeeze stimulus (both paddles for 3 pulses) and checks elements and keydown total.
  task automatic squeeze_run(input logic is_b, input string tag);
    int kd_count;
    logic [1:0] exp_e;
    kd_count = 0;
    for (int t = 1; t <= 60; t++) begin
      dot_key  = (t <= 3);
      dash_key = (t <= 3);
      do_pulse();
      if (t <= 5) exp_e = 2'b01;
      else if (t <= 10) exp_e = 2'b11;
      else if (is_b && t <= 25) exp_e = 2'b10;
      else if (is_b && t <= 30) exp_e = 2'b11;
      else exp_e = 2'b00;
      checkOutput($sformatf("%s element t=%0d", tag, t), 32'(cw_element), 32'(exp_e));
      if (cw_keydown === 1'b1) kd_count++;
    end
    checkOutput({tag, " keydown pulses"}, 32'(kd_count), is_b ? 32'd20 : 32'd5);
    check_idle({tag, " end"});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kd_count;
    logic [1:0] exp_e;

    // Straight mode, hang_time 0: 20 pulses of dot.
    vecs[0] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 7,  1'b1, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 11, 1'b1, 1'b1, 2'b00};
    vecs[4] = '{1'b0, 1'b0, 8,  1'b1, 1'b1, 2'b00};
    vecs[5] = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 2'b00};
    vecs[6] = '{1'b0, 1'b0, 3,  1'b1, 1'b0, 2'b00};
    vecs[7] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 2'b00};
    vecs[8] = '{1'b0, 1'b0, 5,  1'b0, 1'b0, 2'b00};

    rst_n        = 1'b0;
    msec_pulse   = 1'b0;
    dot_key      = 1'b0;
    dash_key     = 1'b0;
    cif.cmd_addr = '0;
    cif.cmd_data = '0;
    cif.cmd_rqst = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // A write to an unused address must not switch to iambic mode.
    write_cmd(6'h0C, 32'h0000_0205);
    dot_key = 1'b1;
    @(negedge clk);
    checkOutput("no pulse power", 32'(cw_power_on), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].dot, vecs[i].dash, vecs[i].pulses);
      checkOutput($sformatf("straight v%0d power", i), 32'(cw_power_on), 32'(vecs[i].exp_power));
      checkOutput($sformatf("straight v%0d keydown", i), 32'(cw_keydown), 32'(vecs[i].exp_keydown));
      checkOutput($sformatf("straight v%0d element", i), 32'(cw_element), 32'(vecs[i].exp_elem));
    end

    // Iambic B, dot_ms 5, dot held 40 pulses: 5 on / 5 off.
    write_cmd(6'h0B, 32'h0000_0205);
    dot_key = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      do_pulse();
      exp_e = (((t - 1) / 5) % 2 == 0) ? 2'b01 : 2'b11;
      checkOutput($sformatf("dots element t=%0d", t), 32'(cw_element), 32'(exp_e));
      checkOutput($sformatf("dots keydown t=%0d", t), 32'(cw_keydown),
                  32'((t >= 10) && ((t - 10) % 10 < 5)));
      checkOutput($sformatf("dots power t=%0d", t), 32'(cw_power_on), 32'(t >= 2));
    end
    applyStimulus(1'b0, 1'b0, 30);
    check_idle("dots end");

    // Squeeze: mode B gives dot+dash, mode A gives a single dot.
    squeeze_run(1'b1, "squeeze B");
    write_cmd(6'h0B, 32'h0000_0105);
    squeeze_run(1'b0, "squeeze A");

    // Reversed paddles in mode A: dash input produces a dot.
    write_cmd(6'h0B, 32'h0000_0505);
    kd_count = 0;
    for (int t = 1; t <= 40; t++) begin
      dash_key = (t <= 10);
      do_pulse();
      exp_e = (t <= 5) ? 2'b01 : (t <= 10) ? 2'b11 : 2'b00;
      checkOutput($sformatf("reverse element t=%0d", t), 32'(cw_element), 32'(exp_e));
      if (cw_keydown === 1'b1) kd_count++;
    end
    checkOutput("reverse keydown pulses", 32'(kd_count), 32'd5);

    // dot_ms written as 0 behaves as 1.
    write_cmd(6'h0B, 32'h0000_0200);
    dot_key = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      do_pulse();
      checkOutput($sformatf("dot_ms0 element t=%0d", t), 32'(cw_element),
                  (t % 2 == 1) ? 32'd1 : 32'd3);
    end
    applyStimulus(1'b0, 1'b0, 30);
    check_idle("dot_ms0 end");

    // Hang: hang_time 20, re-press 10 pulses into POSTKEY, then 24-pulse hang.
    write_cmd(6'h10, 32'h0500_0000);
    write_cmd(6'h0B, 32'h0000_0005);
    for (int t = 1; t <= 72; t++) begin
      dot_key = (t <= 12) || ((t >= 32) && (t <= 35));
      do_pulse();
      checkOutput($sformatf("hang power t=%0d", t), 32'(cw_power_on), 32'(t <= 67));
      checkOutput($sformatf("hang keydown t=%0d", t), 32'(cw_keydown),
                  32'(((t >= 9) && (t <= 20)) || ((t >= 40) && (t <= 43))));
    end

    // Asynchronous reset in the middle of a dash.
    write_cmd(6'h0B, 32'h0000_0205);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("pre-reset element", 32'(cw_element), 32'd2);
    checkOutput("pre-reset keydown", 32'(cw_keydown), 32'd1);
    checkOutput("pre-reset power", 32'(cw_power_on), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      do_pulse();
      checkOutput($sformatf("post-reset keydown t=%0d", t), 32'(cw_keydown), 32'd0);
      checkOutput($sformatf("post-reset power t=%0d", t), 32'(cw_power_on), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("fresh press power", 32'(cw_power_on), 32'd1);
    applyStimulus(1'b0, 1'b0, 20);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
